// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready byte FIFO feeding an 8-bit frame serialiser
// with optional even/odd parity and one or two stop bits.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 10416,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          out_ready,
    input  logic                          in_overflow_clear,
    output logic                          out_tx,
    output logic                          out_busy,
    output logic [$clog2(FIFO_DEPTH):0]   out_fifo_count,
    output logic                          out_fifo_empty,
    output logic                          out_fifo_full,
    output logic                          out_overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    state_t        state, state_d;
    logic [BW-1:0] baud_cnt, baud_cnt_d;
    logic [2:0]    bit_idx, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          push, pop, baud_wrap;
    logic [CW-1:0] count_d;
    logic          tx_d, busy_d, ovf_d;

    assign push      = in_valid && out_ready;
    assign baud_wrap = (baud_cnt == BAUD_LAST);

    // FIFO storage; contents need no reset because the pointers gate every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Frame sequencing, pop decision and next values of every registered output
    always_comb begin
        state_d    = state;
        baud_cnt_d = baud_cnt;
        bit_idx_d  = bit_idx;
        shift_d    = shift_q;
        par_d      = par_q;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!out_fifo_empty) pop = 1'b1;
            end
            START: begin
                if (baud_wrap) begin
                    state_d    = DATA;
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                end else begin
                    baud_cnt_d = baud_cnt + BW'(1);
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    baud_cnt_d = '0;
                    if (bit_idx == 3'd7) begin
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_cnt_d = baud_cnt + BW'(1);
                end
            end
            PARITY: begin
                if (baud_wrap) begin
                    state_d    = STOP;
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                end else begin
                    baud_cnt_d = baud_cnt + BW'(1);
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    baud_cnt_d = '0;
                    if (bit_idx == STOP_LAST) begin
                        if (!out_fifo_empty) pop = 1'b1;
                        else state_d = IDLE;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A pop always launches a fresh frame, from IDLE or straight out of STOP
        if (pop) begin
            state_d    = START;
            baud_cnt_d = '0;
            bit_idx_d  = '0;
            shift_d    = mem[rd_ptr];
            par_d      = (^mem[rd_ptr]) ^ 1'(PARITY_ODD);
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase

        count_d = out_fifo_count + CW'(push) - CW'(pop);
        busy_d  = (state_d != IDLE) || (count_d != '0);
        if (in_overflow_clear)               ovf_d = 1'b0;
        else if (in_valid && out_fifo_full)  ovf_d = 1'b1;
        else                                 ovf_d = out_overflow;
    end

    // State, pointers and all outputs; reset drops any queued or in-flight data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            baud_cnt       <= '0;
            bit_idx        <= '0;
            shift_q        <= '0;
            par_q          <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            out_tx         <= 1'b1;
            out_ready      <= 1'b1;
            out_busy       <= 1'b0;
            out_fifo_count <= '0;
            out_fifo_empty <= 1'b1;
            out_fifo_full  <= 1'b0;
            out_overflow   <= 1'b0;
        end else begin
            state          <= state_d;
            baud_cnt       <= baud_cnt_d;
            bit_idx        <= bit_idx_d;
            shift_q        <= shift_d;
            par_q          <= par_d;
            wr_ptr         <= wr_ptr + AW'(push);
            rd_ptr         <= rd_ptr + AW'(pop);
            out_tx         <= tx_d;
            out_ready      <= (count_d != DEPTH_C);
            out_busy       <= busy_d;
            out_fifo_count <= count_d;
            out_fifo_empty <= (count_d == '0);
            out_fifo_full  <= (count_d == DEPTH_C);
            out_overflow   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three parameterisations driven by shared stimulus,
// each checked every cycle against a frame-level reference model.
module tb_uart_tx_fifo;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       clr = 1'b0;

    logic ready_o [NI];
    logic tx_o    [NI];
    logic busy_o  [NI];
    logic empty_o [NI];
    logic full_o  [NI];
    logic ovf_o   [NI];
    logic [4:0] cnt0, cnt1;
    logic [2:0] cnt2;

    // inst 0: plain 8N1; inst 1: odd parity, 2 stop; inst 2: even parity, depth 4, 3 clk/bit
    uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .out_ready(ready_o[0]),
        .in_overflow_clear(clr), .out_tx(tx_o[0]), .out_busy(busy_o[0]), .out_fifo_count(cnt0),
        .out_fifo_empty(empty_o[0]), .out_fifo_full(full_o[0]), .out_overflow(ovf_o[0]));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .out_ready(ready_o[1]),
        .in_overflow_clear(clr), .out_tx(tx_o[1]), .out_busy(busy_o[1]), .out_fifo_count(cnt1),
        .out_fifo_empty(empty_o[1]), .out_fifo_full(full_o[1]), .out_overflow(ovf_o[1]));
    uart_tx_fifo #(.CLKS_PER_BIT(3), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .out_ready(ready_o[2]),
        .in_overflow_clear(clr), .out_tx(tx_o[2]), .out_busy(busy_o[2]), .out_fifo_count(cnt2),
        .out_fifo_empty(empty_o[2]), .out_fifo_full(full_o[2]), .out_overflow(ovf_o[2]));

    always #5 clk = ~clk;

    function automatic int p_cpb(input int i);   return (i == 2) ? 3 : 4;  endfunction
    function automatic int p_depth(input int i); return (i == 2) ? 4 : 16; endfunction
    function automatic bit p_par(input int i);   return (i != 0);          endfunction
    function automatic bit p_odd(input int i);   return (i == 1);          endfunction
    function automatic int p_stop(input int i);  return (i == 1) ? 2 : 1;  endfunction

    function automatic logic [31:0] dut_cnt(input int i);
        case (i)
            0:       return 32'(cnt0);
            1:       return 32'(cnt1);
            default: return 32'(cnt2);
        endcase
    endfunction

    // Reference model: queue contents as a plain array, frame as a list of line levels
    logic [7:0]  mbuf  [NI][16];
    int          msz   [NI];
    logic [11:0] fbits [NI];
    int          nbits [NI];
    int          pos   [NI];
    logic        movf  [NI];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            msz[i]  = 0;
            pos[i]  = -1;
            movf[i] = 1'b0;
        end
    endtask

    task automatic build_frame(input int i, input logic [7:0] d);
        int n;
        fbits[i]    = '1;
        fbits[i][0] = 1'b0;
        for (int b = 0; b < 8; b++) fbits[i][1+b] = d[b];
        n = 9;
        if (p_par(i)) begin
            fbits[i][9] = (^d) ^ p_odd(i);
            n = 10;
        end
        nbits[i] = n + p_stop(i);
    endtask

    // Advance the model across one rising edge using the inputs held before it
    task automatic model_step();
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < NI; i++) begin
                int pre_sz;
                bit rdy;
                pre_sz = msz[i];
                rdy    = (pre_sz < p_depth(i));
                if (pos[i] >= 0) begin
                    pos[i]++;
                    if (pos[i] == nbits[i] * p_cpb(i)) pos[i] = -1;
                end
                if (pos[i] < 0 && pre_sz > 0) begin
                    build_frame(i, mbuf[i][0]);
                    for (int k = 0; k < 15; k++) mbuf[i][k] = mbuf[i][k+1];
                    msz[i]--;
                    pos[i] = 0;
                end
                if (in_valid && rdy) begin
                    mbuf[i][msz[i]] = in_data;
                    msz[i]++;
                end
                if (clr)                    movf[i] = 1'b0;
                else if (in_valid && !rdy)  movf[i] = 1'b1;
            end
        end
    endtask

    task automatic model_compare();
        for (int i = 0; i < NI; i++) begin
            logic etx;
            etx = (pos[i] < 0) ? 1'b1 : fbits[i][pos[i] / p_cpb(i)];
            chk($sformatf("tx[%0d]", i),    32'(tx_o[i]),    32'(etx));
            chk($sformatf("count[%0d]", i), dut_cnt(i),      32'(msz[i]));
            chk($sformatf("empty[%0d]", i), 32'(empty_o[i]), 32'(msz[i] == 0));
            chk($sformatf("full[%0d]", i),  32'(full_o[i]),  32'(msz[i] == p_depth(i)));
            chk($sformatf("ready[%0d]", i), 32'(ready_o[i]), 32'(msz[i] != p_depth(i)));
            chk($sformatf("busy[%0d]", i),  32'(busy_o[i]),  32'(pos[i] >= 0 || msz[i] > 0));
            chk($sformatf("ovf[%0d]", i),   32'(ovf_o[i]),   32'(movf[i]));
        end
    endtask

    // One clock: model follows the rising edge, outputs compared on the falling edge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        model_compare();
    endtask

    task automatic wait_idle(input int budget);
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < budget && !idle; c++) begin
            tick();
            idle = !busy_o[0] && !busy_o[1] && !busy_o[2];
        end
        chk("drain", 32'(idle), 32'd1);
    endtask

    typedef struct {
        int   scen;
        int   inst;
        int   cyc;
        logic tx;
        logic busy;
    } vec_t;
    vec_t tv[$];

    initial begin
        int lowcnt;
        // scen 0: 0xA5 alone; scen 1: 0x03 then 0x07 on consecutive edges
        tv.push_back('{0,0, 1,1'b0,1'b1}); tv.push_back('{0,0, 4,1'b0,1'b1});
        tv.push_back('{0,0, 5,1'b1,1'b1}); tv.push_back('{0,0, 8,1'b1,1'b1});
        tv.push_back('{0,0, 9,1'b0,1'b1}); tv.push_back('{0,0,13,1'b1,1'b1});
        tv.push_back('{0,0,17,1'b0,1'b1}); tv.push_back('{0,0,21,1'b0,1'b1});
        tv.push_back('{0,0,25,1'b1,1'b1}); tv.push_back('{0,0,29,1'b0,1'b1});
        tv.push_back('{0,0,32,1'b0,1'b1}); tv.push_back('{0,0,33,1'b1,1'b1});
        tv.push_back('{0,0,37,1'b1,1'b1}); tv.push_back('{0,0,40,1'b1,1'b1});
        tv.push_back('{0,0,41,1'b1,1'b0});
        tv.push_back('{0,1,37,1'b1,1'b1}); tv.push_back('{0,1,48,1'b1,1'b1});
        tv.push_back('{0,1,49,1'b1,1'b0});
        tv.push_back('{0,2, 3,1'b0,1'b1}); tv.push_back('{0,2, 4,1'b1,1'b1});
        tv.push_back('{0,2,13,1'b0,1'b1}); tv.push_back('{0,2,28,1'b0,1'b1});
        tv.push_back('{0,2,30,1'b0,1'b1}); tv.push_back('{0,2,31,1'b1,1'b1});
        tv.push_back('{0,2,33,1'b1,1'b1}); tv.push_back('{0,2,34,1'b1,1'b0});
        tv.push_back('{1,0, 9,1'b1,1'b1}); tv.push_back('{1,0,13,1'b0,1'b1});
        tv.push_back('{1,0,40,1'b1,1'b1}); tv.push_back('{1,0,41,1'b0,1'b1});
        tv.push_back('{1,0,44,1'b0,1'b1}); tv.push_back('{1,0,45,1'b1,1'b1});
        tv.push_back('{1,0,81,1'b1,1'b0});
        tv.push_back('{1,1,37,1'b1,1'b1}); tv.push_back('{1,1,41,1'b1,1'b1});
        tv.push_back('{1,1,48,1'b1,1'b1}); tv.push_back('{1,1,49,1'b0,1'b1});
        tv.push_back('{1,1,85,1'b0,1'b1}); tv.push_back('{1,1,89,1'b1,1'b1});
        tv.push_back('{1,1,96,1'b1,1'b1}); tv.push_back('{1,1,97,1'b1,1'b0});
        tv.push_back('{1,2,28,1'b0,1'b1}); tv.push_back('{1,2,33,1'b1,1'b1});
        tv.push_back('{1,2,34,1'b0,1'b1}); tv.push_back('{1,2,61,1'b1,1'b1});
        tv.push_back('{1,2,64,1'b1,1'b1}); tv.push_back('{1,2,67,1'b1,1'b0});

        // Reset, then idle with the model watching every output
        #1 rst_n = 1'b0;
        model_reset();
        for (int c = 0; c < 3; c++) tick();
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) tick();

        // Table-driven frame timing
        for (int s = 0; s < 2; s++) begin
            in_data  = (s == 0) ? 8'hA5 : 8'h03;
            in_valid = 1'b1;
            tick();
            for (int k = 1; k <= 100; k++) begin
                if (s == 1 && k == 1) begin
                    in_data  = 8'h07;
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                tick();
                for (int t = 0; t < tv.size(); t++) begin
                    if (tv[t].scen == s && tv[t].cyc == k) begin
                        chk($sformatf("vec s%0d i%0d c%0d tx", s, tv[t].inst, k),
                            32'(tx_o[tv[t].inst]), 32'(tv[t].tx));
                        chk($sformatf("vec s%0d i%0d c%0d busy", s, tv[t].inst, k),
                            32'(busy_o[tv[t].inst]), 32'(tv[t].busy));
                    end
                end
            end
            in_valid = 1'b0;
            wait_idle(200);
        end

        // Fill to full, overflow, back-to-back drain, sticky clear
        for (int b = 0; b < 17; b++) begin
            in_data  = 8'(b);
            in_valid = 1'b1;
            tick();
            if (b < 2) chk($sformatf("fill count b%0d", b), 32'(cnt0), 32'd1);
        end
        chk("full count", 32'(cnt0), 32'd16);
        chk("full ready", 32'(ready_o[0]), 32'd0);
        in_data = 8'h11;
        tick();
        in_valid = 1'b0;
        chk("ovf set", 32'(ovf_o[0]), 32'd1);
        chk("ovf count", 32'(cnt0), 32'd16);
        wait_idle(2000);
        chk("ovf sticky", 32'(ovf_o[0]), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("ovf clear", 32'(ovf_o[0]), 32'd0);

        // Asynchronous reset in the middle of data bit 3 with bytes queued
        for (int b = 0; b < 5; b++) begin
            in_data  = 8'($urandom);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 14; c++) tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("async tx[%0d]", i),    32'(tx_o[i]),   32'd1);
            chk($sformatf("async count[%0d]", i), dut_cnt(i),     32'd0);
            chk($sformatf("async busy[%0d]", i),  32'(busy_o[i]), 32'd0);
        end
        tick();
        tick();
        rst_n  = 1'b1;
        lowcnt = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            for (int i = 0; i < NI; i++) if (tx_o[i] !== 1'b1) lowcnt++;
        end
        chk("post-reset line high", 32'(lowcnt), 32'd0);

        // Randomised traffic alternating heavy and light phases
        for (int c = 0; c < 3000; c++) begin
            if (((c / 200) % 2) == 0) in_valid = ($urandom_range(3) != 0);
            else                      in_valid = ($urandom_range(19) == 0);
            in_data = 8'($urandom);
            clr     = ($urandom_range(63) == 0);
            tick();
        end
        in_valid = 1'b0;
        clr      = 1'b0;
        wait_idle(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
